ucode_sequencer: RTL and testbench

- Microcode dispatch and sequencing stage that sits directly upstream of the 512x8 microcode jump ROM.
- Accepts a decoded opcode from the instruction register and forms the 9-bit jump-ROM address.
- Takes the ROM's 8-bit entry-point output one cycle later and loads it into the micro-PC.
- Steps the micro-PC (increment, conditional branch, end) and hands the micro-PC to the control store.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/upc_next.sv | 39 +++
 rtl/ucode_sequencer.sv | 106 ++++++++++
 tb/tb_ucode_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the microcode dispatch/sequencing stage.
// The address/data widths here must match the 512x8 jump ROM.
package cpu_pkg;

    localparam int OPC_WIDTH = 8;
    localparam int ROM_AW    = 9;
    localparam int UPC_W     = 8;

    localparam logic [UPC_W-1:0] UPC_RESET = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        LOAD   = 2'd2,
        EXEC   = 2'd3
    } state_t;

endpackage

// File: rtl/upc_next.sv
// Combinational next micro-PC selection for EXEC: abort > stall > end > taken branch > increment.
// Also flags an increment that rolls the micro-PC over from all-ones to zero.
module upc_next #(
    parameter int UPC_W = 8
) (
    input  logic [UPC_W-1:0] i_upc,
    input  logic             i_abort,
    input  logic             i_stall,
    input  logic             i_uc_end,
    input  logic             i_uc_branch,
    input  logic             i_cond_true,
    input  logic [UPC_W-1:0] i_uc_target,
    output logic [UPC_W-1:0] o_upc_nxt,
    output logic             o_exit,
    output logic             o_wrap
);

    localparam logic [UPC_W-1:0] ONE = {{(UPC_W-1){1'b0}}, 1'b1};

    always_comb begin
        o_upc_nxt = i_upc;
        o_exit    = 1'b0;
        o_wrap    = 1'b0;
        if (i_abort) begin
            o_exit = 1'b1;
        end else if (i_stall) begin
            o_upc_nxt = i_upc;
        end else if (i_uc_end) begin
            o_exit = 1'b1;
        end else if (i_uc_branch && i_cond_true) begin
            // A taken branch to zero is not a rollover.
            o_upc_nxt = i_uc_target;
        end else begin
            o_upc_nxt = i_upc + ONE;
            o_wrap    = &i_upc;
        end
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode dispatch: forms the jump-ROM address from the opcode, loads the ROM entry point
// into the micro-PC and steps it until the sequence ends or is aborted.
//
// state  | meaning
// IDLE   | ready for an opcode; rom_addr latched on accept
// DECODE | jump ROM samples rom_addr on the closing edge
// LOAD   | rom_dout valid; loaded into upc
// EXEC   | upc stepping under end/branch/stall/abort control
module ucode_sequencer
    import cpu_pkg::*;
#(
    parameter int OPC_WIDTH = cpu_pkg::OPC_WIDTH,
    parameter int ROM_AW    = cpu_pkg::ROM_AW,
    parameter int UPC_W     = cpu_pkg::UPC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ir_valid,
    output logic                 ir_ready,
    input  logic [OPC_WIDTH-1:0] ir_opcode,
    input  logic                 ir_mode,
    output logic [ROM_AW-1:0]    rom_addr,
    input  logic [UPC_W-1:0]     rom_dout,
    input  logic                 uc_end,
    input  logic                 uc_branch,
    input  logic [UPC_W-1:0]     uc_target,
    input  logic                 cond_true,
    input  logic                 stall,
    input  logic                 abort,
    output logic [UPC_W-1:0]     upc,
    output logic                 upc_valid,
    output logic                 upc_wrap
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROM_AW-1:0]  r_rom_addr;
    logic [UPC_W-1:0]   r_upc;
    logic               r_upc_valid;
    logic               r_upc_wrap;
    logic [UPC_W-1:0]   w_upc_nxt;
    logic               w_exit;
    logic               w_wrap;
    logic               w_accept;

    assign w_accept = (r_state == IDLE) && ir_valid && !abort;

    upc_next #(.UPC_W(UPC_W)) u_upc_next (
        .i_upc       (r_upc),
        .i_abort     (abort),
        .i_stall     (stall),
        .i_uc_end    (uc_end),
        .i_uc_branch (uc_branch),
        .i_cond_true (cond_true),
        .i_uc_target (uc_target),
        .o_upc_nxt   (w_upc_nxt),
        .o_exit      (w_exit),
        .o_wrap      (w_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = DECODE;
            DECODE:  w_state_nxt = abort ? IDLE : LOAD;
            LOAD:    w_state_nxt = abort ? IDLE : EXEC;
            EXEC:    if (w_exit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rom_addr  <= '0;
            r_upc       <= UPC_RESET;
            r_upc_valid <= 1'b0;
            r_upc_wrap  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_upc_wrap <= 1'b0;
            if (w_accept) begin
                r_rom_addr <= {ir_mode, ir_opcode};
            end
            if (r_state == LOAD && !abort) begin
                r_upc       <= rom_dout;
                r_upc_valid <= 1'b1;
            end
            if (r_state == EXEC) begin
                if (w_exit) begin
                    r_upc_valid <= 1'b0;
                end else begin
                    r_upc      <= w_upc_nxt;
                    r_upc_wrap <= w_wrap;
                end
            end
        end
    end

    assign ir_ready  = (r_state == IDLE);
    assign rom_addr  = r_rom_addr;
    assign upc       = r_upc;
    assign upc_valid = r_upc_valid;
    assign upc_wrap  = r_upc_wrap;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a 1-cycle synchronous jump-ROM model.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_ucode_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] ir_opcode;
    logic       ir_mode;
    logic [8:0] rom_addr;
    logic [7:0] rom_dout;
    logic       uc_end;
    logic       uc_branch;
    logic [7:0] uc_target;
    logic       cond_true;
    logic       stall;
    logic       abort;
    logic [7:0] upc;
    logic       upc_valid;
    logic       upc_wrap;

    int checks;
    int failures;

    logic [7:0] mem [512];

    ucode_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir_opcode (ir_opcode),
        .ir_mode   (ir_mode),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .uc_end    (uc_end),
        .uc_branch (uc_branch),
        .uc_target (uc_target),
        .cond_true (cond_true),
        .stall     (stall),
        .abort     (abort),
        .upc       (upc),
        .upc_valid (upc_valid),
        .upc_wrap  (upc_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h012] = 8'h40;
        mem[9'h112] = 8'hFE;

        rst_n     = 1'b0;
        ir_valid  = 1'b0;
        ir_opcode = 8'h00;
        ir_mode   = 1'b0;
        uc_end    = 1'b0;
        uc_branch = 1'b0;
        uc_target = 8'h00;
        cond_true = 1'b0;
        stall     = 1'b0;
        abort     = 1'b0;

        step();
        step();
        check("rst_upc", upc, 8'h00);
        check("rst_upc_valid", upc_valid, 1'b0);
        check("rst_upc_wrap", upc_wrap, 1'b0);
        check("rst_ir_ready", ir_ready, 1'b1);
        check("rst_rom_addr", rom_addr, 9'h000);
        rst_n = 1'b1;
        step();

        // Dispatch opcode 0x12, mode 0
        ir_opcode = 8'h12;
        ir_mode   = 1'b0;
        ir_valid  = 1'b1;
        step();
        ir_valid = 1'b0;
        check("disp_rom_addr", rom_addr, 9'h012);
        check("disp_ready_low", ir_ready, 1'b0);
        step();
        check("disp_valid_early", upc_valid, 1'b0);
        step();
        check("disp_upc", upc, 8'h40);
        check("disp_upc_valid", upc_valid, 1'b1);
        step();
        check("inc_41", upc, 8'h41);

        // Not-taken branch falls through to increment
        uc_branch = 1'b1;
        cond_true = 1'b0;
        uc_target = 8'h80;
        step();
        uc_branch = 1'b0;
        check("br_not_taken", upc, 8'h42);

        // End, then back-to-back dispatch
        uc_end = 1'b1;
        step();
        uc_end = 1'b0;
        check("end_valid", upc_valid, 1'b0);
        check("end_ready", ir_ready, 1'b1);
        check("end_rom_addr_hold", rom_addr, 9'h012);
        ir_valid = 1'b1;
        step();
        ir_valid = 1'b0;
        step();
        step();
        check("b2b_upc", upc, 8'h40);
        check("b2b_valid", upc_valid, 1'b1);
        step();
        check("b2b_inc", upc, 8'h41);

        // Taken branch
        uc_branch = 1'b1;
        cond_true = 1'b1;
        uc_target = 8'h80;
        step();
        uc_branch = 1'b0;
        cond_true = 1'b0;
        check("br_taken", upc, 8'h80);
        check("br_taken_valid", upc_valid, 1'b1);

        // End and immediately dispatch mode 1 (ROM 0x112 -> 0xFE)
        uc_end = 1'b1;
        step();
        uc_end = 1'b0;
        ir_mode  = 1'b1;
        ir_valid = 1'b1;
        step();
        ir_valid = 1'b0;
        check("wrap_rom_addr", rom_addr, 9'h112);
        step();
        step();
        check("wrap_upc_fe", upc, 8'hFE);
        step();
        check("wrap_upc_ff", upc, 8'hFF);
        check("wrap_pulse_ff", upc_wrap, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_upc", upc, 8'hFF);
            check("stall_no_wrap", upc_wrap, 1'b0);
        end
        stall = 1'b0;
        step();
        check("wrap_upc_00", upc, 8'h00);
        check("wrap_pulse", upc_wrap, 1'b1);
        step();
        check("wrap_upc_01", upc, 8'h01);
        check("wrap_pulse_off", upc_wrap, 1'b0);

        // Branch to zero is not a wrap
        uc_branch = 1'b1;
        cond_true = 1'b1;
        uc_target = 8'h00;
        step();
        uc_branch = 1'b0;
        cond_true = 1'b0;
        check("br_zero_upc", upc, 8'h00);
        check("br_zero_no_wrap", upc_wrap, 1'b0);

        uc_end = 1'b1;
        step();
        uc_end = 1'b0;
        check("end2_ready", ir_ready, 1'b1);

        // Abort in LOAD
        ir_mode  = 1'b0;
        ir_valid = 1'b1;
        step();
        ir_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_load_valid", upc_valid, 1'b0);
        check("abort_load_ready", ir_ready, 1'b1);
        check("abort_load_upc", upc, 8'h00);
        step();
        check("abort_load_valid2", upc_valid, 1'b0);

        // Abort in IDLE blocks a simultaneous accept
        ir_mode  = 1'b1;
        ir_valid = 1'b1;
        abort    = 1'b1;
        step();
        ir_valid = 1'b0;
        abort    = 1'b0;
        check("abort_idle_ready", ir_ready, 1'b1);
        check("abort_idle_addr", rom_addr, 9'h012);

        // Asynchronous reset in EXEC
        ir_mode  = 1'b0;
        ir_valid = 1'b1;
        step();
        ir_valid = 1'b0;
        step();
        step();
        step();
        check("pre_rst_upc", upc, 8'h41);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_upc", upc, 8'h00);
        check("arst_valid", upc_valid, 1'b0);
        check("arst_ready", ir_ready, 1'b1);
        check("arst_rom_addr", rom_addr, 9'h000);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", ir_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
